// File: rtl/sub_fp8_seq_pkg.sv
// ============================================================================
// sub_fp8_seq_pkg : FP8 field widths, special encodings, FSM states, packing
// Revision: 1.0
// ============================================================================
`default_nettype none

package sub_fp8_seq_pkg;

    localparam int FP8_EXP_W = 3;
    localparam int FP8_MAN_W = 4;

    localparam logic [7:0] FP8_QNAN = 8'h78;
    localparam logic [7:0] FP8_PINF = 8'h70;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ARITH = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Zero wins over overflow, overflow over underflow flush.
    function automatic logic [7:0] fp8_pack(
        input logic                 s,
        input logic [FP8_EXP_W-1:0] e,
        input logic [FP8_MAN_W:0]   m
    );
        logic [7:0] res;
        if (m == '0)
            res = 8'h00;
        else if (e == 3'd7)
            res = {s, FP8_PINF[6:0]};
        else if (e == 3'd0)
            res = {s, 7'h00};
        else
            res = {s, e, m[FP8_MAN_W-1:0]};
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_fp8_seq_adder.sv
// ============================================================================
// adder_nbit_cin : N-bit adder with carry in/out, selectable architecture
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_nbit_cin #(
    parameter int N         = 4,
    parameter int IMPL_TYPE = 0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    generate
        if (IMPL_TYPE == 0) begin : g_behav
            assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        end else begin : g_ripple
            logic [N:0] w_c;
            assign w_c[0] = cin;
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
                assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
            end
            assign cout = w_c[N];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sub_fp8_seq_classify.sv
// ============================================================================
// fp8_classify : decodes zero/Inf/NaN and the 5-bit hidden-one mantissa
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp8_classify
    import sub_fp8_seq_pkg::*;
(
    input  logic [6:0]         mag,
    output logic               is_zero,
    output logic               is_inf,
    output logic               is_nan,
    output logic [FP8_MAN_W:0] man5
);

    logic [FP8_EXP_W-1:0] w_exp;
    logic [FP8_MAN_W-1:0] w_man;

    assign w_exp   = mag[6:4];
    assign w_man   = mag[3:0];
    assign is_zero = (w_exp == 3'd0) && (w_man == '0);
    assign is_inf  = (w_exp == 3'd7) && (w_man == '0);
    assign is_nan  = (w_exp == 3'd7) && (w_man != '0);
    assign man5    = {~is_zero, w_man};

endmodule

`default_nettype wire

// File: rtl/sub_fp8_seq.sv
// ============================================================================
// sub_fp8_seq : serial FP8 subtractor a - b with valid/ready handshakes
// Revision: 1.0
// ============================================================================
`default_nettype none

module sub_fp8_seq #(
    parameter int IMPL_TYPE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       busy
);
    import sub_fp8_seq_pkg::*;

    logic [2:0]           r_state;
    logic [2:0]           r_cnt;
    logic [FP8_MAN_W:0]   r_man_l;
    logic [FP8_MAN_W:0]   r_man_s;
    logic [FP8_EXP_W-1:0] r_exp;
    logic                 r_sign;
    logic                 r_eff_sub;
    logic [7:0]           r_result;

    logic [7:0]           w_nb;
    logic                 w_a_zero, w_a_inf, w_a_nan;
    logic                 w_b_zero, w_b_inf, w_b_nan;
    logic [FP8_MAN_W:0]   w_a_man, w_b_man;
    logic                 w_a_big;
    logic [FP8_EXP_W-1:0] w_l_exp, w_s_exp, w_exp_d, w_exp_adj, w_exp_step;
    logic [FP8_MAN_W:0]   w_l_man, w_s_man;
    logic [FP8_MAN_W+1:0] w_msum, w_mop;
    logic                 w_spec;
    logic [7:0]           w_spec_res;
    logic                 w_norm_stop;
    logic                 w_unused_d_co, w_unused_m_co, w_unused_e_co;

    assign w_nb = {~b[7], b[6:0]};

    fp8_classify u_cls_a (.mag(a[6:0]), .is_zero(w_a_zero), .is_inf(w_a_inf), .is_nan(w_a_nan), .man5(w_a_man));
    fp8_classify u_cls_b (.mag(b[6:0]), .is_zero(w_b_zero), .is_inf(w_b_inf), .is_nan(w_b_nan), .man5(w_b_man));

    // Magnitude ordering; a tie keeps a as the larger operand.
    assign w_a_big = (a[6:0] >= b[6:0]);
    assign w_l_exp = w_a_big ? a[6:4] : b[6:4];
    assign w_s_exp = w_a_big ? b[6:4] : a[6:4];
    assign w_l_man = w_a_big ? w_a_man : w_b_man;
    assign w_s_man = w_a_big ? w_b_man : w_a_man;

    adder_nbit_cin #(.N(FP8_EXP_W), .IMPL_TYPE(IMPL_TYPE)) u_exp_diff (
        .a(w_l_exp), .b(~w_s_exp), .cin(1'b1), .sum(w_exp_d), .cout(w_unused_d_co)
    );

    always_comb begin
        w_spec     = 1'b1;
        w_spec_res = FP8_QNAN;
        if (w_a_nan || w_b_nan)
            w_spec_res = FP8_QNAN;
        else if (w_a_inf && w_b_inf && (a[7] != w_nb[7]))
            w_spec_res = FP8_QNAN;
        else if (w_a_inf)
            w_spec_res = {a[7], FP8_PINF[6:0]};
        else if (w_b_inf)
            w_spec_res = {w_nb[7], FP8_PINF[6:0]};
        else if (w_a_zero && w_b_zero)
            w_spec_res = 8'h00;
        else
            w_spec = 1'b0;
    end

    // Subtraction as L + ~S + 1; L >= S after alignment so bit 5 stays clear.
    assign w_mop = r_eff_sub ? ~{1'b0, r_man_s} : {1'b0, r_man_s};

    adder_nbit_cin #(.N(FP8_MAN_W+2), .IMPL_TYPE(IMPL_TYPE)) u_man_add (
        .a({1'b0, r_man_l}), .b(w_mop), .cin(r_eff_sub), .sum(w_msum), .cout(w_unused_m_co)
    );

    assign w_exp_step = (r_state == S_ARITH) ? 3'b001 : 3'b111;

    adder_nbit_cin #(.N(FP8_EXP_W), .IMPL_TYPE(IMPL_TYPE)) u_exp_adj (
        .a(r_exp), .b(w_exp_step), .cin(1'b0), .sum(w_exp_adj), .cout(w_unused_e_co)
    );

    assign w_norm_stop = (r_man_l == '0) || r_man_l[FP8_MAN_W] || (r_exp == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_man_l   <= '0;
            r_man_s   <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_result  <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_spec) begin
                            r_result <= w_spec_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_sign    <= w_a_big ? a[7] : w_nb[7];
                            r_exp     <= w_l_exp;
                            r_man_l   <= w_l_man;
                            r_man_s   <= w_s_man;
                            r_cnt     <= w_exp_d;
                            r_eff_sub <= (a[7] != w_nb[7]);
                            r_state   <= S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    if (r_cnt != '0) begin
                        r_man_s <= r_man_s >> 1;
                        r_cnt   <= r_cnt - 3'd1;
                    end else begin
                        r_state <= S_ARITH;
                    end
                end
                S_ARITH: begin
                    if (w_msum[FP8_MAN_W+1]) begin
                        r_man_l <= w_msum[FP8_MAN_W+1:1];
                        r_exp   <= w_exp_adj;
                    end else begin
                        r_man_l <= w_msum[FP8_MAN_W:0];
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (w_norm_stop) begin
                        r_result <= fp8_pack(r_sign, r_exp, r_man_l);
                        r_state  <= S_DONE;
                    end else begin
                        r_man_l <= r_man_l << 1;
                        r_exp   <= w_exp_adj;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_sub_fp8_seq.sv
// ============================================================================
// tb_sub_fp8_seq : scoreboard bench for the serial FP8 subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sub_fp8_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready, out_valid, busy;
    logic [7:0] result;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         lat_q[$];

    always #5 clk = ~clk;

    sub_fp8_seq #(.IMPL_TYPE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Latency counts clock edges from the accept edge (inclusive) to the first out_valid cycle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_op,
                          input logic [7:0] want, input int want_lat, input int hold);
        int         k;
        logic [7:0] e_res;
        int         e_lat;
        @(posedge clk); #1;
        check_eq("in_ready_idle", in_ready, 1);
        a = ta; b = tb_op; in_valid = 1'b1; out_ready = 1'b0;
        exp_q.push_back(want);
        lat_q.push_back(want_lat);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        check_eq("in_ready_drop", in_ready, 0);
        k = 1;
        while (!out_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) begin
            check_eq("out_valid_timeout", 0, 1);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end else begin
            e_res = exp_q.pop_front();
            e_lat = lat_q.pop_front();
            check_eq($sformatf("result_%h_%h", ta, tb_op), result, e_res);
            check_eq($sformatf("latency_%h_%h", ta, tb_op), k, e_lat);
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
                @(posedge clk); #1;
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_result", result, e_res);
                check_eq("hold_in_ready", in_ready, 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check_eq("hs_valid_low", out_valid, 0);
            check_eq("hs_idle_ready", in_ready, 1);
            check_eq("hs_busy_low", busy, 0);
            check_eq("hs_result_kept", result, e_res);
        end
    endtask

    initial begin
        #2;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 8'h00);
        check_eq("rst_busy", busy, 0);
        #10 rst_n = 1'b1;

        run_op(8'h30, 8'h20, 8'h20, 6, 5);
        run_op(8'h20, 8'hB0, 8'h38, 5, 0);
        run_op(8'h35, 8'h35, 8'h00, 4, 0);
        run_op(8'h70, 8'h70, 8'h78, 1, 0);
        run_op(8'h70, 8'hF0, 8'h70, 1, 0);
        run_op(8'h10, 8'h70, 8'hF0, 1, 0);
        run_op(8'h72, 8'h30, 8'h78, 1, 0);
        run_op(8'h00, 8'h00, 8'h00, 1, 0);
        run_op(8'h6F, 8'hEF, 8'h70, 4, 0);
        run_op(8'h18, 8'h10, 8'h00, 5, 0);
        run_op(8'h30, 8'h00, 8'h30, 7, 0);
        run_op(8'h2F, 8'h41, 8'hB4, 7, 2);

        // Abort a long alignment mid-flight; its scoreboard entry is discarded.
        @(posedge clk); #1;
        a = 8'h60; b = 8'h10; in_valid = 1'b1;
        exp_q.push_back(8'h20);
        lat_q.push_back(9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("busy_align", busy, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        #1;
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_result", result, 8'h00);
        check_eq("abort_busy", busy, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(8'h30, 8'h20, 8'h20, 6, 0);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
